// File: rtl/scb_pkg.sv
// rtl/scb_pkg.sv - shared register scoreboard constants (SCB_BYPASS_EN selects write-back forwarding waiver)
package scb_pkg;
    localparam int REG_AW  = 5;
    localparam int REG_NUM = 32;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
endpackage

// File: rtl/scb_counter.sv
// rtl/scb_counter.sv - saturating up/down pending-write counter with clear
module scb_counter
    import scb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    // Count issued-but-not-retired writes; hold at max and at zero, clear wins.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_W'(CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - issue hazard scoreboard for the register file (SCB_BYPASS_EN enables same-cycle write-back waiver)
module reg_scoreboard
    import scb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid,
    input  logic [REG_AW-1:0]  issue_rs,
    input  logic [REG_AW-1:0]  issue_rt,
    input  logic               issue_rs_use,
    input  logic               issue_rt_use,
    input  logic [REG_AW-1:0]  issue_rd,
    input  logic               issue_wen,
    output logic               stall,
    input  logic               wb_valid,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic               flush,
    input  logic [REG_AW-1:0]  dbu_ra,
    output logic               dbu_ready,
    output logic [REG_NUM-1:0] busy_vec
);

    logic [CNT_W-1:0] cnt [REG_NUM];
    logic             accept;
    logic [CNT_W-1:0] rs_cnt, rt_cnt, rd_cnt, dbu_cnt;
    logic             rs_wv, rt_wv, dbu_wv;
    logic             rs_hz, rt_hz, rd_full;

    // Register 0 is hard-wired zero and never tracked.
    assign cnt[0] = '0;

    assign accept = issue_valid && !stall;

    for (genvar i = 1; i < REG_NUM; i++) begin : g_cnt
        scb_counter u_cnt (
            .clk (clk),
            .rst (rst),
            .clr (flush),
            .inc (accept && issue_wen && issue_rd == REG_AW'(i)),
            .dec (wb_valid && wb_rd == REG_AW'(i)),
            .cnt (cnt[i])
        );
    end

    // Source/destination hazard evaluation and debug readiness.
    always_comb begin
        rs_cnt  = cnt[issue_rs];
        rt_cnt  = cnt[issue_rt];
        rd_cnt  = cnt[issue_rd];
        dbu_cnt = cnt[dbu_ra];
`ifdef SCB_BYPASS_EN
        // Last outstanding write retiring now is forwarded by the write-first file.
        rs_wv  = wb_valid && wb_rd == issue_rs && rs_cnt == CNT_W'(1);
        rt_wv  = wb_valid && wb_rd == issue_rt && rt_cnt == CNT_W'(1);
        dbu_wv = wb_valid && wb_rd == dbu_ra && dbu_cnt == CNT_W'(1);
`else
        rs_wv  = 1'b0;
        rt_wv  = 1'b0;
        dbu_wv = 1'b0;
`endif
        rs_hz     = issue_rs_use && issue_rs != '0 && rs_cnt != '0 && !rs_wv;
        rt_hz     = issue_rt_use && issue_rt != '0 && rt_cnt != '0 && !rt_wv;
        rd_full   = issue_wen && issue_rd != '0 && rd_cnt == CNT_W'(CNT_MAX);
        stall     = issue_valid && (rs_hz || rt_hz || rd_full);
        dbu_ready = dbu_ra == '0 || dbu_cnt == '0 || dbu_wv;
    end

    // Busy view taken straight from the counter registers.
    always_comb begin
        busy_vec = '0;
        for (int i = 1; i < REG_NUM; i++) begin
            busy_vec[i] = cnt[i] != '0;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic        issue_rs_use, issue_rt_use, issue_wen;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [4:0]  dbu_ra;
    logic        dbu_ready;
    logic [31:0] busy_vec;

    int vectors = 0;
    int miscompares = 0;
    bit started = 1'b0;
    int cnt_m [32];

`ifdef SCB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_scoreboard dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rs_use(issue_rs_use), .issue_rt_use(issue_rt_use),
        .issue_rd(issue_rd), .issue_wen(issue_wen), .stall(stall),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .dbu_ra(dbu_ra), .dbu_ready(dbu_ready), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    // A source is unusable while any write to it is pending, unless that
    // write is the only one and retires this very cycle (bypass builds).
    function automatic bit src_blocked(logic [4:0] a, logic used);
        if (!used || a == 0 || cnt_m[a] == 0) return 1'b0;
        if (BYP && wb_valid && wb_rd == a && cnt_m[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        bit full;
        full = issue_wen && issue_rd != 0 && cnt_m[issue_rd] == 3;
        return issue_valid && (src_blocked(issue_rs, issue_rs_use) ||
                               src_blocked(issue_rt, issue_rt_use) || full);
    endfunction

    function automatic bit m_ready();
        return !src_blocked(dbu_ra, 1'b1);
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = cnt_m[r] > 0;
        return b;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending-write count per register, advanced at each clock edge.
    always @(posedge clk) begin
        bit acc;
        int n;
        acc = issue_valid && !m_stall();
        for (int r = 0; r < 32; r++) begin
            n = cnt_m[r];
            if (rst || flush || r == 0) begin
                n = 0;
            end else begin
                if (acc && issue_wen && issue_rd == r) n = n + 1;
                if (wb_valid && wb_rd == r) n = n - 1;
                if (n < 0) n = 0;
                if (n > 3) n = 3;
            end
            cnt_m[r] <= n;
        end
    end

    // Compare DUT against the model away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("stall", {31'b0, stall}, {31'b0, m_stall()});
            check("dbu_ready", {31'b0, dbu_ready}, {31'b0, m_ready()});
            check("busy_vec", busy_vec, m_busy());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rs_use = 0;
        issue_rt_use = 0; issue_rd = 0; issue_wen = 0;
        wb_valid = 0; wb_rd = 0; flush = 0; dbu_ra = 0;
    endtask

    initial begin
        idle();
        for (int r = 0; r < 32; r++) cnt_m[r] = 0;
        rst = 1; tick(); tick(); rst = 0; started = 1'b1;

        // Reset state
        check("rst_busy", busy_vec, 32'h0);
        check("rst_stall", {31'b0, stall}, 32'h0);
        for (int a = 0; a < 32; a += 5) begin
            dbu_ra = 5'(a); #1;
            check("rst_dbu_ready", {31'b0, dbu_ready}, 32'h1);
        end
        idle();

        // RAW hazard on rs
        issue_valid = 1; issue_wen = 1; issue_rd = 5; #1;
        check("s2_first_issue", {31'b0, stall}, 32'h0);
        tick();
        issue_wen = 0; issue_rs = 5; issue_rs_use = 1; #1;
        check("s2_raw_stall", {31'b0, stall}, 32'h1);
        check("s2_busy", busy_vec, 32'h20);
        tick();
        check("s2_raw_hold", {31'b0, stall}, 32'h1);
        wb_valid = 1; wb_rd = 5; #1;
        check("s2_wb_cycle", {31'b0, stall}, BYP ? 32'h0 : 32'h1);
        tick();
        wb_valid = 0; #1;
        check("s2_after_wb", {31'b0, stall}, 32'h0);
        check("s2_busy_clr", busy_vec, 32'h0);
        tick(); idle();

        // RAW hazard on rt, only when rt is used
        issue_valid = 1; issue_wen = 1; issue_rd = 6; tick();
        issue_wen = 0; issue_rt = 6; issue_rt_use = 0; #1;
        check("rt_unused", {31'b0, stall}, 32'h0);
        issue_rt_use = 1; #1;
        check("rt_used", {31'b0, stall}, 32'h1);
        idle(); wb_valid = 1; wb_rd = 6; tick(); idle(); tick();

        // Destination counter saturation
        issue_valid = 1; issue_wen = 1; issue_rd = 7;
        tick(); tick(); tick();
        check("s3_busy", busy_vec, 32'h80);
        check("s3_full", {31'b0, stall}, 32'h1);
        wb_valid = 1; wb_rd = 7; #1;
        check("s3_full_wb", {31'b0, stall}, 32'h1);
        tick();
        check("s3_inc_dec", {31'b0, stall}, 32'h0);
        tick();
        wb_valid = 0; #1;
        check("s3_still2", {31'b0, stall}, 32'h0);
        tick();
        check("s3_full_again", {31'b0, stall}, 32'h1);
        idle(); wb_valid = 1; wb_rd = 7;
        tick(); tick(); tick();
        idle(); #1;
        check("s3_drained", busy_vec, 32'h0);

        // Register 0
        issue_valid = 1; issue_wen = 1; issue_rd = 0; #1;
        check("s4_rd0", {31'b0, stall}, 32'h0);
        tick();
        issue_wen = 0; issue_rs_use = 1; issue_rt_use = 1; #1;
        check("s4_rs0", {31'b0, stall}, 32'h0);
        tick();
        check("s4_busy", busy_vec, 32'h0);
        idle();

        // Flush discards pending writes and the flush-cycle issue
        issue_valid = 1; issue_wen = 1; issue_rd = 3; tick();
        issue_rd = 9; tick();
        check("s5_busy", busy_vec, 32'h208);
        issue_rd = 4; flush = 1; #1;
        check("s5_flush_nostall", {31'b0, stall}, 32'h0);
        tick(); idle(); #1;
        check("s5_flushed", busy_vec, 32'h0);
        tick();
        check("s5_rd4_dropped", busy_vec, 32'h0);

        // Debug readiness and underflow
        issue_valid = 1; issue_wen = 1; issue_rd = 12; tick();
        idle(); dbu_ra = 12; #1;
        check("s6_not_ready", {31'b0, dbu_ready}, 32'h0);
        wb_valid = 1; wb_rd = 12; #1;
        check("s6_wb_ready", {31'b0, dbu_ready}, BYP ? 32'h1 : 32'h0);
        tick();
        wb_valid = 0; #1;
        check("s6_ready", {31'b0, dbu_ready}, 32'h1);
        wb_valid = 1; wb_rd = 13; tick();
        idle(); dbu_ra = 13; #1;
        check("s6_no_underflow", busy_vec, 32'h0);
        check("s6_r13_ready", {31'b0, dbu_ready}, 32'h1);

        // Reset mid-operation
        issue_valid = 1; issue_wen = 1; issue_rd = 20; tick();
        idle(); #1;
        check("rst_mid_busy", busy_vec, 32'h0010_0000);
        rst = 1; tick(); rst = 0; #1;
        check("rst_mid_clear", busy_vec, 32'h0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
